// File: rtl/udma_apb_cfg_arbiter.sv
// Round-robin APB3 configuration master for the uDMA subsystem.
// Serialises write / read / atomic read-modify-write commands from NB_REQ requesters.
module udma_apb_cfg_arbiter #(
    parameter int unsigned NB_REQ         = 4,
    parameter int unsigned APB_ADDR_WIDTH = 32
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic [NB_REQ-1:0]                req_valid_i,
    output logic [NB_REQ-1:0]                req_ready_o,
    input  logic [NB_REQ*2-1:0]              req_op_i,
    input  logic [NB_REQ*APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NB_REQ*32-1:0]             req_wdata_i,
    input  logic [NB_REQ*32-1:0]             req_clr_i,
    output logic [NB_REQ-1:0]                rsp_valid_o,
    output logic [31:0]                      rsp_rdata_o,
    output logic                             rsp_err_o,
    output logic                             busy_o,
    output logic [APB_ADDR_WIDTH-1:0]        paddr_o,
    output logic [31:0]                      pwdata_o,
    output logic                             pwrite_o,
    output logic                             psel_o,
    output logic                             penable_o,
    input  logic [31:0]                      prdata_i,
    input  logic                             pready_i,
    input  logic                             pslverr_i
);

    localparam int unsigned IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_WR_SETUP,
        ST_WR_ACCESS
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_RMW   = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    op_t                 op_q, op_d;
    logic [31:0]         set_q, set_d;
    logic [31:0]         clr_q, clr_d;
    logic [31:0]         old_q, old_d;

    logic [NB_REQ-1:0]         ready_d;
    logic [NB_REQ-1:0]         rsp_valid_d;
    logic [31:0]               rsp_rdata_d;
    logic                      rsp_err_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_d;
    logic [31:0]               pwdata_d;
    logic                      pwrite_d;
    logic                      psel_d;
    logic                      penable_d;

    logic                      gnt_found;
    logic [IDX_W-1:0]          gnt_idx;
    logic [IDX_W-1:0]          gnt_next;
    op_t                       gnt_op;
    logic [APB_ADDR_WIDTH-1:0] gnt_addr;
    logic [31:0]               gnt_wdata;
    logic [31:0]               gnt_clr;
    logic [NB_REQ-1:0]         gnt_oh;
    logic [NB_REQ-1:0]         owner_oh;

    logic                      fin;
    logic [31:0]               fin_rdata;
    logic                      fin_err;

    function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
        int unsigned w;
        w = (v >= NB_REQ) ? v - NB_REQ : v;
        return w[IDX_W-1:0];
    endfunction

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            if (!gnt_found && req_valid_i[wrap_idx(32'(rr_ptr_q) + i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_idx(32'(rr_ptr_q) + i);
            end
        end
    end

    always_comb begin
        gnt_op    = OP_WRITE;
        gnt_addr  = '0;
        gnt_wdata = '0;
        gnt_clr   = '0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                gnt_op    = op_t'(req_op_i[2*i +: 2]);
                gnt_addr  = req_addr_i[APB_ADDR_WIDTH*i +: APB_ADDR_WIDTH];
                gnt_wdata = req_wdata_i[32*i +: 32];
                gnt_clr   = req_clr_i[32*i +: 32];
            end
        end
    end

    assign gnt_next = (gnt_idx == IDX_W'(NB_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    assign gnt_oh   = NB_REQ'(1) << gnt_idx;
    assign owner_oh = NB_REQ'(1) << owner_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            op_q     <= OP_WRITE;
            set_q    <= '0;
            clr_q    <= '0;
            old_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            set_q    <= set_d;
            clr_q    <= clr_d;
            old_q    <= old_d;
        end
    end

    // Every output is a flop loaded with the value belonging to the next state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            req_ready_o <= '0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            busy_o      <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            pwrite_o    <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
        end else begin
            req_ready_o <= ready_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_rdata_o <= rsp_rdata_d;
            rsp_err_o   <= rsp_err_d;
            busy_o      <= (state_d != ST_IDLE);
            paddr_o     <= paddr_d;
            pwdata_o    <= pwdata_d;
            pwrite_o    <= pwrite_d;
            psel_o      <= psel_d;
            penable_o   <= penable_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        op_d        = op_q;
        set_d       = set_q;
        clr_d       = clr_q;
        old_d       = old_q;
        ready_d     = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_o;
        rsp_err_d   = rsp_err_o;
        paddr_d     = paddr_o;
        pwdata_d    = pwdata_o;
        pwrite_d    = pwrite_o;
        psel_d      = psel_o;
        penable_d   = penable_o;
        fin         = 1'b0;
        fin_rdata   = '0;
        fin_err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
                if (gnt_found) begin
                    ready_d  = gnt_oh;
                    owner_d  = gnt_idx;
                    op_d     = gnt_op;
                    set_d    = gnt_wdata;
                    clr_d    = gnt_clr;
                    rr_ptr_d = gnt_next;
                    state_d  = ST_SETUP;
                    // Reserved ops pass through SETUP without touching the bus.
                    if (gnt_op != OP_RSVD) begin
                        psel_d   = 1'b1;
                        paddr_d  = gnt_addr;
                        pwrite_d = (gnt_op == OP_WRITE);
                        pwdata_d = (gnt_op == OP_WRITE) ? gnt_wdata : '0;
                    end
                end
            end
            ST_SETUP: begin
                if (op_q == OP_RSVD) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    penable_d = 1'b1;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    if (op_q == OP_RMW && !pslverr_i) begin
                        old_d     = prdata_i;
                        penable_d = 1'b0;
                        pwrite_d  = 1'b1;
                        pwdata_d  = (prdata_i & ~clr_q) | set_q;
                        state_d   = ST_WR_SETUP;
                    end else begin
                        fin       = 1'b1;
                        fin_rdata = (op_q == OP_WRITE) ? '0 : prdata_i;
                        fin_err   = pslverr_i;
                    end
                end
            end
            ST_WR_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_WR_ACCESS;
            end
            ST_WR_ACCESS: begin
                if (pready_i) begin
                    fin       = 1'b1;
                    fin_rdata = old_q;
                    fin_err   = pslverr_i;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fin) begin
            rsp_valid_d = owner_oh;
            rsp_rdata_d = fin_rdata;
            rsp_err_d   = fin_err;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            pwrite_d    = 1'b0;
            state_d     = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_udma_apb_cfg_arbiter.sv
// Directed bench for udma_apb_cfg_arbiter: APB slave with register file, wait and error injection.
module tb_udma_apb_cfg_arbiter;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic [3:0]    req_valid_i;
    logic [3:0]    req_ready_o;
    logic [7:0]    req_op_i;
    logic [127:0]  req_addr_i;
    logic [127:0]  req_wdata_i;
    logic [127:0]  req_clr_i;
    logic [3:0]    rsp_valid_o;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic          busy_o;
    logic [31:0]   paddr_o;
    logic [31:0]   pwdata_o;
    logic          pwrite_o;
    logic          psel_o;
    logic          penable_o;
    logic [31:0]   prdata_i;
    logic          pready_i;
    logic          pslverr_i;

    udma_apb_cfg_arbiter #(.NB_REQ(4), .APB_ADDR_WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_clr_i   (req_clr_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .pwrite_o    (pwrite_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    // APB slave: 16-word register file, optional read wait states and read error.
    logic [31:0]  mem [16];
    int unsigned  rd_wait = 0;
    bit           rd_err  = 1'b0;
    int unsigned  wcnt    = 0;
    logic         ld_en   = 1'b0;
    logic [3:0]   ld_addr = '0;
    logic [31:0]  ld_data = '0;

    always_comb begin
        pready_i  = psel_o && penable_o && (wcnt >= (pwrite_o ? 32'd0 : rd_wait));
        prdata_i  = (psel_o && !pwrite_o) ? mem[paddr_o[5:2]] : '0;
        pslverr_i = pready_i && !pwrite_o && rd_err;
    end

    always @(posedge clk_i) begin
        wcnt <= (psel_o && penable_o && !pready_i) ? wcnt + 1 : 0;
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (psel_o && penable_o && pready_i && pwrite_o && !pslverr_i)
            mem[paddr_o[5:2]] <= pwdata_o;
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] clr);
        req_op_i[2*i +: 2]     = op;
        req_addr_i[32*i +: 32] = addr;
        req_wdata_i[32*i +: 32] = wdata;
        req_clr_i[32*i +: 32]  = clr;
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return k;
        return -1;
    endfunction

    // Results of the last run_txn call.
    int unsigned t_lat, t_psel, t_pwrite;
    bit          t_gap, t_done;
    logic [3:0]  t_ready, t_rsp;
    logic [31:0] t_rdata;
    logic        t_err;

    task automatic run_txn(input int unsigned bound);
        int unsigned n;
        bit seen_psel, dropped;
        n = 0; t_lat = 0; t_psel = 0; t_pwrite = 0; t_gap = 0; t_done = 0;
        t_ready = '0; t_rsp = '0; t_rdata = '0; t_err = 1'b0;
        seen_psel = 0; dropped = 0;
        while (!t_done && n < bound) begin
            tick();
            n++;
            if (req_ready_o != 0) begin
                t_ready     = req_ready_o;
                req_valid_i = '0;
            end
            if (psel_o) begin
                t_psel++;
                if (dropped) t_gap = 1;
                seen_psel = 1;
            end else if (seen_psel) begin
                dropped = 1;
            end
            if (pwrite_o) t_pwrite++;
            if (rsp_valid_o != 0) begin
                t_done  = 1;
                t_lat   = n;
                t_rsp   = rsp_valid_o;
                t_rdata = rsp_rdata_o;
                t_err   = rsp_err_o;
            end
        end
        if (!t_done) check("txn_timeout", 32'd0, 32'd1);
    endtask

    int          grants[$];
    int          gcyc[$];
    int          rsp_idx[$];
    logic [31:0] rsp_dat[$];
    int          exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rstn_i      = 1'b0;
        req_valid_i = '0;
        req_op_i    = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_clr_i   = '0;
        tick();
        tick();

        check("rst_ready",  32'(req_ready_o), 32'd0);
        check("rst_rsp",    {27'd0, rsp_valid_o, rsp_err_o}, 32'd0);
        check("rst_rdata",  rsp_rdata_o, 32'd0);
        check("rst_apb",    {27'd0, busy_o, psel_o, penable_o, pwrite_o, 1'b0}, 32'd0);
        check("rst_paddr",  paddr_o, 32'd0);
        check("rst_pwdata", pwdata_o, 32'd0);

        // Four simultaneous reads at reset release; req0 comes back during the third grant.
        for (int i = 0; i < 4; i++) load(4'(i), 32'h100 + i);
        for (int i = 0; i < 4; i++) set_req(i, 2'b01, 32'(4 * i), 32'd0, 32'd0);
        req_valid_i = 4'b1111;
        rstn_i = 1'b1;
        begin
            int n;
            int g;
            n = 0;
            while (rsp_idx.size() < 5 && n < 80) begin
                tick();
                n++;
                if (req_ready_o != 0) begin
                    g = oh2idx(req_ready_o);
                    grants.push_back(g);
                    gcyc.push_back(n);
                    if (g >= 0) req_valid_i[g] = 1'b0;
                    if (grants.size() == 3) req_valid_i[0] = 1'b1;
                end
                if (rsp_valid_o != 0) begin
                    rsp_idx.push_back(oh2idx(rsp_valid_o));
                    rsp_dat.push_back(rsp_rdata_o);
                end
            end
        end
        req_valid_i = '0;
        check("rr_grant_count", 32'(grants.size()), 32'd5);
        check("rr_rsp_count", 32'(rsp_idx.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < grants.size())  check("rr_grant_order", 32'(grants[k]), 32'(exp_order[k]));
            if (k < rsp_idx.size()) begin
                check("rr_rsp_order", 32'(rsp_idx[k]), 32'(exp_order[k]));
                check("rr_rdata", rsp_dat[k], 32'h100 + 32'(exp_order[k]));
            end
        end
        if (gcyc.size() >= 2) check("rr_spacing", 32'(gcyc[1] - gcyc[0]), 32'd3);
        tick();

        // Single write, stepped phase by phase.
        set_req(0, 2'b00, 32'h0, 32'h4, 32'h0);
        req_valid_i = 4'b0001;
        tick();
        req_valid_i = '0;
        check("wr_ready",       32'(req_ready_o), 32'h1);
        check("wr_setup_ctl",   {28'd0, busy_o, psel_o, penable_o, pwrite_o}, 32'b1101);
        check("wr_setup_paddr", paddr_o, 32'h0);
        check("wr_setup_pwdata", pwdata_o, 32'h4);
        tick();
        check("wr_access_ctl",  {28'd0, busy_o, psel_o, penable_o, pwrite_o}, 32'b1111);
        tick();
        check("wr_rsp_valid",   32'(rsp_valid_o), 32'h1);
        check("wr_rsp_err",     32'(rsp_err_o), 32'd0);
        check("wr_rsp_rdata",   rsp_rdata_o, 32'd0);
        check("wr_idle_ctl",    {28'd0, busy_o, psel_o, penable_o, pwrite_o}, 32'd0);
        check("wr_mem",         mem[0], 32'h4);
        tick();

        // RMW with two read wait states.
        load(4'd0, 32'h0000_00F0);
        rd_wait = 2;
        set_req(1, 2'b10, 32'h0, 32'h1, 32'h10);
        req_valid_i = 4'b0010;
        run_txn(40);
        rd_wait = 0;
        check("rmw_ready",  32'(t_ready), 32'h2);
        check("rmw_rsp",    32'(t_rsp), 32'h2);
        check("rmw_rdata",  t_rdata, 32'h0000_00F0);
        check("rmw_err",    32'(t_err), 32'd0);
        check("rmw_lat",    t_lat, 32'd7);
        check("rmw_psel",   t_psel, 32'd6);
        check("rmw_gap",    32'(t_gap), 32'd0);
        check("rmw_pwrite", t_pwrite, 32'd2);
        check("rmw_mem",    mem[0], 32'h0000_00E1);
        tick();

        // RMW whose read phase errors: aborted before any write.
        load(4'd2, 32'h55);
        rd_err = 1'b1;
        set_req(0, 2'b10, 32'h8, 32'hFF00, 32'hF);
        req_valid_i = 4'b0001;
        run_txn(20);
        rd_err = 1'b0;
        check("rmwerr_rsp",    32'(t_rsp), 32'h1);
        check("rmwerr_err",    32'(t_err), 32'd1);
        check("rmwerr_rdata",  t_rdata, 32'h55);
        check("rmwerr_pwrite", t_pwrite, 32'd0);
        check("rmwerr_lat",    t_lat, 32'd3);
        check("rmwerr_mem",    mem[2], 32'h55);
        tick();

        // Reserved op.
        set_req(2, 2'b11, 32'h4, 32'h0, 32'h0);
        req_valid_i = 4'b0100;
        run_txn(20);
        check("rsvd_ready", 32'(t_ready), 32'h4);
        check("rsvd_rsp",   32'(t_rsp), 32'h4);
        check("rsvd_err",   32'(t_err), 32'd1);
        check("rsvd_rdata", t_rdata, 32'd0);
        check("rsvd_psel",  t_psel, 32'd0);
        check("rsvd_lat",   t_lat, 32'd2);
        tick();

        // Reset asserted while the RMW write setup is on the bus.
        load(4'd3, 32'h77);
        set_req(1, 2'b10, 32'hC, 32'h1, 32'h0);
        req_valid_i = 4'b0010;
        tick();
        req_valid_i = '0;
        check("rstmid_ready", 32'(req_ready_o), 32'h2);
        tick();
        tick();
        check("rstmid_wrsetup", {28'd0, busy_o, psel_o, penable_o, pwrite_o}, 32'b1101);
        rstn_i = 1'b0;
        #1;
        check("rstmid_ctl",    {27'd0, busy_o, psel_o, penable_o, pwrite_o, rsp_err_o}, 32'd0);
        check("rstmid_paddr",  paddr_o, 32'd0);
        check("rstmid_pwdata", pwdata_o, 32'd0);
        check("rstmid_rsp",    {24'd0, req_ready_o, rsp_valid_o}, 32'd0);
        check("rstmid_rdata",  rsp_rdata_o, 32'd0);
        tick();
        check("rstmid_norsp",  32'(rsp_valid_o), 32'd0);
        rstn_i = 1'b1;
        check("rstmid_mem",    mem[3], 32'h77);
        set_req(0, 2'b01, 32'h0, 32'h0, 32'h0);
        set_req(3, 2'b01, 32'hC, 32'h0, 32'h0);
        req_valid_i = 4'b1001;
        tick();
        req_valid_i = '0;
        check("rstmid_regrant", 32'(req_ready_o), 32'h1);
        tick();
        tick();
        check("rstmid_rsp0",   32'(rsp_valid_o), 32'h1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
